// File: rtl/fir_pkg.sv
// Constants and state type shared by the feeder and the FIR datapath.
package fir_pkg;

    localparam int unsigned TAPS   = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned PASSES = TAPS / LANES;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WIND,
        RUN
    } feeder_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO; head is visible combinationally at the read pointer.
module fir_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_feeder.sv
// Sequences coefficient frames and buffered samples onto the FIR wind/load/compute pins.
module fir_feeder #(
    parameter int unsigned TAPS  = fir_pkg::TAPS,
    parameter int unsigned LANES = fir_pkg::LANES,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   coef_valid,
    input  logic [15:0]            coef_data,
    output logic                   coef_ready,
    input  logic                   samp_valid,
    input  logic [15:0]            samp_data,
    output logic                   samp_ready,
    output logic                   fir_wind,
    output logic                   fir_load,
    output logic                   fir_in_valid,
    output logic [15:0]            fir_data,
    output logic                   coef_loaded,
    output logic [$clog2(DEPTH):0] fifo_level
);

    import fir_pkg::*;

    localparam int unsigned PASSES_N = TAPS / LANES;
    localparam int unsigned BW       = $clog2(TAPS + 1);
    localparam int unsigned PW       = $clog2(PASSES_N + 1);

    generate
        if ((TAPS % LANES) != 0) begin : g_bad_taps
            $error("fir_feeder: TAPS must be a multiple of LANES");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fir_feeder: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    feeder_state_t state;
    logic [BW-1:0] beat_cnt;
    logic [PW-1:0] pass_cnt;
    logic [15:0]   head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;

    assign coef_ready = (state == IDLE) || (state == WIND);
    assign samp_ready = ~full;
    assign push       = samp_valid & samp_ready;
    // A pending coefficient beat in IDLE wins over dispatching a sample.
    assign pop        = (state == IDLE) & ~coef_valid & coef_loaded & ~empty;

    fir_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (samp_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            pass_cnt     <= '0;
            coef_loaded  <= 1'b0;
            fir_wind     <= 1'b0;
            fir_load     <= 1'b0;
            fir_in_valid <= 1'b0;
            fir_data     <= '0;
        end else begin
            fir_wind     <= 1'b0;
            fir_load     <= 1'b0;
            fir_in_valid <= (state == RUN);
            case (state)
                IDLE: begin
                    if (coef_valid) begin
                        fir_wind <= 1'b1;
                        fir_data <= coef_data;
                        beat_cnt <= BW'(1);
                        if (TAPS == 1) begin
                            coef_loaded <= 1'b1;
                        end else begin
                            state <= WIND;
                        end
                    end else if (pop) begin
                        fir_load <= 1'b1;
                        fir_data <= head;
                        pass_cnt <= '0;
                        state    <= RUN;
                    end
                end
                WIND: begin
                    if (coef_valid) begin
                        fir_wind <= 1'b1;
                        fir_data <= coef_data;
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == BW'(TAPS - 1)) begin
                            state       <= IDLE;
                            coef_loaded <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    pass_cnt <= pass_cnt + PW'(1);
                    if (pass_cnt == PW'(PASSES_N - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_feeder.sv
// Randomized and directed stimulus for fir_feeder against a queue/countdown reference model.
module tb_fir_feeder;

    localparam int unsigned TAPS   = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned PASSES = TAPS / LANES;
    localparam int unsigned DEPTH  = 4;

    logic                   clk;
    logic                   rst;
    logic                   coef_valid;
    logic [15:0]            coef_data;
    logic                   coef_ready;
    logic                   samp_valid;
    logic [15:0]            samp_data;
    logic                   samp_ready;
    logic                   fir_wind;
    logic                   fir_load;
    logic                   fir_in_valid;
    logic [15:0]            fir_data;
    logic                   coef_loaded;
    logic [$clog2(DEPTH):0] fifo_level;

    fir_feeder #(
        .TAPS  (TAPS),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coef_valid   (coef_valid),
        .coef_data    (coef_data),
        .coef_ready   (coef_ready),
        .samp_valid   (samp_valid),
        .samp_data    (samp_data),
        .samp_ready   (samp_ready),
        .fir_wind     (fir_wind),
        .fir_load     (fir_load),
        .fir_in_valid (fir_in_valid),
        .fir_data     (fir_data),
        .coef_loaded  (coef_loaded),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model: beats taken in the open frame, compute cycles still owed,
    // and the buffered samples as a plain queue.
    int          frame_beats;
    int          run_left;
    bit          loaded;
    logic [15:0] q[$];
    bit          e_wind;
    bit          e_load;
    bit          e_inv;
    logic [15:0] e_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit cv, input logic [15:0] cd,
                        input bit sv, input logic [15:0] sd);
        bit busy;
        bit acc;
        bit pop;
        bit push;
        @(negedge clk);
        rst        = r;
        coef_valid = cv;
        coef_data  = cd;
        samp_valid = sv;
        samp_data  = sd;
        #1;
        busy = (run_left > 0);
        check("coef_ready", 32'(coef_ready), 32'(!busy));
        check("samp_ready", 32'(samp_ready), 32'(q.size() < DEPTH));
        if (r) begin
            frame_beats = 0;
            run_left    = 0;
            loaded      = 0;
            q.delete();
            e_wind = 0;
            e_load = 0;
            e_inv  = 0;
            e_data = '0;
        end else begin
            acc  = cv && !busy;
            pop  = !busy && frame_beats == 0 && !cv && loaded && q.size() > 0;
            push = sv && q.size() < DEPTH;
            e_wind = acc;
            e_load = pop;
            e_inv  = busy;
            if (acc) e_data = cd;
            else if (pop) e_data = q[0];
            if (acc) begin
                frame_beats++;
                if (frame_beats == TAPS) begin
                    frame_beats = 0;
                    loaded      = 1;
                end
            end
            if (busy) run_left--;
            if (pop) begin
                void'(q.pop_front());
                run_left = PASSES;
            end
            if (push) q.push_back(sd);
        end
        @(posedge clk);
        #1;
        check("fir_wind", 32'(fir_wind), 32'(e_wind));
        check("fir_load", 32'(fir_load), 32'(e_load));
        check("fir_in_valid", 32'(fir_in_valid), 32'(e_inv));
        check("fir_data", 32'(fir_data), 32'(e_data));
        check("coef_loaded", 32'(coef_loaded), 32'(loaded));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, '0);
    endtask

    // One coefficient frame of values base..base+TAPS-1, optionally pausing after a beat.
    task automatic frame(input int base, input int gap_after, input int gap_len);
        for (int b = 1; b <= TAPS; b++) begin
            step(0, 1, 16'(base + b - 1), 0, '0);
            if (b == gap_after) idle(gap_len);
        end
    endtask

    initial begin
        rst = 1'b1; coef_valid = 1'b0; coef_data = '0; samp_valid = 1'b0; samp_data = '0;
        frame_beats = 0; run_left = 0; loaded = 0; e_wind = 0; e_load = 0; e_inv = 0; e_data = '0;
        repeat (2) @(posedge clk);

        // Reset then quiet idle.
        do_reset();
        idle(10);

        // Frame 1..16 back to back, then a frame with a stall after beat 7.
        frame(1, 0, 0);
        idle(2);
        frame(100, 7, 3);
        idle(2);

        // Samples buffered before any frame, dispatched once a frame lands.
        do_reset();
        step(0, 0, '0, 1, 16'h000A);
        step(0, 0, '0, 1, 16'h000B);
        idle(4);
        frame(1, 0, 0);
        idle(14);

        // Fill while dispatch is blocked, then keep offering as the frame completes.
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 16'(16'h0200 + i));
        for (int b = 1; b <= TAPS; b++) step(0, 1, 16'(b), 1, 16'(16'h0300 + b));
        for (int i = 0; i < 24; i++) step(0, 0, '0, 1, 16'(16'h0400 + i));
        idle(10);

        // Coefficients offered during RUN, and both channels pending in IDLE.
        step(0, 0, '0, 1, 16'h0055);
        step(0, 0, '0, 1, 16'h0066);
        step(0, 0, '0, 0, '0);
        for (int b = 1; b <= TAPS + 6; b++) step(0, 1, 16'(16'h0700 + b), 0, '0);
        idle(12);

        // Reset at beat 9 of a frame.
        do_reset();
        frame(1, 0, 0);
        for (int b = 1; b <= 8; b++) step(0, 1, 16'(b), 0, '0);
        do_reset();
        idle(6);

        // Reset during the second compute cycle.
        frame(1, 0, 0);
        step(0, 0, '0, 1, 16'h0ABC);
        step(0, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);
        do_reset();
        idle(8);

        // Randomized traffic with rare resets.
        for (int phase = 0; phase < 4; phase++) begin
            int unsigned cprob;
            int unsigned sprob;
            cprob = (phase == 0) ? 60 : (phase == 1) ? 15 : (phase == 2) ? 3 : 35;
            sprob = (phase == 2) ? 90 : (phase == 3) ? 20 : 50;
            for (int i = 0; i < 800; i++) begin
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 99) < cprob),
                     16'($urandom),
                     ($urandom_range(0, 99) < sprob),
                     16'($urandom));
            end
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fir_feeder.md
Name: fir_feeder

Overview:
Upstream sequencer for the 16-tap, 4-lane FIR datapath.
- Accepts coefficient frames and a sample stream over two valid/ready channels.
- Buffers samples in a small FIFO.
- Drives the FIR's wind/load/in_valid/data pins with the required spacing: one shift-in pulse, then PASSES consecutive compute cycles per sample.
- Guarantees data never shifts during a compute window and that no sample is dispatched before a full coefficient frame is loaded.

Parameters:
TAPS, 16, filter length; also the number of beats in one coefficient frame.
LANES, 4, MAC lanes in the FIR. PASSES = TAPS/LANES; TAPS % LANES must be 0, otherwise elaboration fails.
DEPTH, 4, sample FIFO entries; must be a power of 2, at least 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
coef_valid  in  1  coefficient beat offered
coef_data  in  16  coefficient value
coef_ready  out  1  coefficient beat accepted when valid&ready
samp_valid  in  1  sample offered
samp_data  in  16  sample value
samp_ready  out  1  sample accepted when valid&ready
fir_wind  out  1  shift fir_data into the weight line
fir_load  out  1  shift fir_data into the data line
fir_in_valid  out  1  FIR compute-enable
fir_data  out  16  shared data bus to FIR
coef_loaded  out  1  at least one complete frame loaded since reset
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Reset: one clock and a synchronous active-high reset, as decided.
- rst sampled high on a clk edge clears state to IDLE and clears all counters.
- FIFO is emptied and coef_loaded is cleared.
- fir_wind, fir_load, fir_in_valid and fir_data are all 0.
- Reset mid-frame or mid-RUN abandons the operation; no partial pulses follow.

States: IDLE, WIND, RUN.
- coef_ready = (state==IDLE) | (state==WIND).
- samp_ready = (fifo_level != DEPTH) in every state. There is no same-cycle bypass: a pop while full does not raise ready in that cycle.
- FIFO push on samp_valid&samp_ready is independent of state. Samples buffer during WIND and RUN.

IDLE:
- If coef_valid, the beat is accepted, beat_cnt becomes 1, and state goes to WIND. Coefficients take priority over samples.
- Else if coef_loaded and FIFO is non-empty, pop the head, pass_cnt becomes 0, and state goes to RUN.
- Else stay in IDLE.

WIND:
- Each accepted beat increments beat_cnt.
- The beat that makes beat_cnt==TAPS returns state to IDLE and sets coef_loaded.
- coef_valid low mid-frame simply stalls; the counter holds and there is no timeout.

RUN:
- pass_cnt increments each cycle.
- At pass_cnt==PASSES-1, state returns to IDLE.

Outputs are registered, with one cycle of latency:
- fir_wind(t+1) = coef beat accepted at t; fir_data(t+1) = coef_data(t).
- fir_load(t+1) = pop at t; fir_data(t+1) = FIFO head at t.
- fir_in_valid(t+1) = (state==RUN at t).
- With no wind or load pulse, fir_data holds its previous value.

Sample timeline:
- Pop at t gives fir_load at t+1 and fir_in_valid over t+2..t+PASSES+1.
- The earliest next pop is t+PASSES+1, so the next fir_load is at t+PASSES+2.
- Sustained throughput is one sample per PASSES+1 cycles (5 at defaults).
- fir_load/fir_wind never coincide with fir_in_valid.

Reload: a new coefficient frame may start only from IDLE, and replaces all TAPS weights. coef_loaded stays 1.

Decomposition:
- Shared package fir_pkg holds the feeder state enum and the TAPS, LANES and PASSES constants, so they agree with the FIR datapath.
- One sub-module, fir_sample_fifo: synchronous FIFO with parameters DEPTH and width 16.
  - Registered read pointer; head visible combinationally.
  - Ports: push, pop, full, empty, level.

Test Plan:
1. Reset then idle 10 cycles -> all fir_* outputs 0, samp_ready=1, coef_ready=1, coef_loaded=0, fifo_level=0.
2. Coefficients 1..16 with continuous valid from IDLE -> 16 consecutive fir_wind pulses, fir_data 1..16 one cycle after each accept, coef_loaded=1 after the 16th. Repeat with coef_valid dropped for 3 cycles after beat 7 -> 16 pulses total, state stays in WIND during the gap.
3. Samples 0x0A, 0x0B pushed before any coefficient frame -> fifo_level=2, no fir_load. After the frame completes: fir_load with 0x0A, 4 fir_in_valid cycles, then fir_load with 0x0B exactly 5 cycles after the first load.
4. Continuous samp_valid with dispatch blocked (coef_loaded=0) -> samp_ready falls once fifo_level=4. A 5th sample presented on the same cycle as a pop is not accepted.
5. coef_valid raised during RUN -> coef_ready=0 until RUN ends. In IDLE, with both channels pending, the coefficient frame is chosen first and the buffered sample dispatches after beat 16.
6. rst asserted at beat 9 of WIND and, separately, during the 2nd fir_in_valid cycle -> next cycle all outputs 0, coef_loaded=0, fifo_level=0, no further in_valid pulses.
